rca_nibble_seq: RTL and testbench

- Nibble-serial wide adder controller that sits directly upstream of the 4-bit `rca` adder.
- Latches WIDTH-bit operands through a valid/ready handshake and feeds one nibble per cycle into one internal `rca` instance (ports a, b, cin, s, cout).
- Registers the carry between nibbles and collects the nibble sums into a WIDTH-bit result.
- Presents the result through an output valid/ready handshake, so wide adds reuse the existing 4-bit adder.

---
 rtl/rca_nibble_seq.sv | 149 ++++++++++++++
 tb/tb_rca_nibble_seq.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/rca_nibble_seq.sv
// Nibble-serial WIDTH-bit adder that reuses one 4-bit ripple-carry adder.
// Optional macro RCA_NIBBLE_SEQ_OVF_EN adds a registered signed-overflow output ovf.

module rca (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] s,
  output logic       cout
);
  logic [4:0] c;

  always_comb begin
    c    = 5'd0;
    s    = 4'd0;
    c[0] = cin;
    for (int i = 0; i < 4; i++) begin
      s[i]   = a[i] ^ b[i] ^ c[i];
      c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
    cout = c[4];
  end
endmodule

module rca_nibble_seq #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             busy
`ifdef RCA_NIBBLE_SEQ_OVF_EN
  , output logic           ovf
`endif
);
  localparam int N  = WIDTH / 4;
  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam logic [IW-1:0] LAST = IW'(N - 1);

  generate
    if ((WIDTH % 4) != 0 || WIDTH < 4) begin : g_bad_width
      $error("rca_nibble_seq: WIDTH must be a multiple of 4 and >= 4");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t              state;
  logic [N-1:0][3:0]   a_lat;
  logic [N-1:0][3:0]   b_lat;
  logic [N-1:0][3:0]   s_nib;
  logic                carry;
  logic [IW-1:0]       idx;
  logic [3:0]          nib_a;
  logic [3:0]          nib_b;
  logic [3:0]          nib_s;
  logic                nib_c;

  assign nib_a = a_lat[idx];
  assign nib_b = b_lat[idx];
  assign s     = s_nib;

  rca u_rca (
    .a    (nib_a),
    .b    (nib_b),
    .cin  (carry),
    .s    (nib_s),
    .cout (nib_c)
  );

  // in_ready is registered so it rises on the edge that leaves reset or DONE.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      idx       <= '0;
      carry     <= 1'b0;
      a_lat     <= '0;
      b_lat     <= '0;
      s_nib     <= '0;
      cout      <= 1'b0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      in_ready  <= 1'b0;
`ifdef RCA_NIBBLE_SEQ_OVF_EN
      ovf       <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (in_ready && in_valid) begin
            a_lat    <= a;
            b_lat    <= b;
            carry    <= cin;
            s_nib    <= '0;
            idx      <= '0;
            in_ready <= 1'b0;
            busy     <= 1'b1;
            state    <= CALC;
          end else begin
            in_ready <= 1'b1;
          end
        end
        CALC: begin
          s_nib[idx] <= nib_s;
          carry      <= nib_c;
          if (idx == LAST) begin
            cout      <= nib_c;
            out_valid <= 1'b1;
            state     <= DONE;
`ifdef RCA_NIBBLE_SEQ_OVF_EN
            // carry into the MSB is recovered from the MSB sum bit
            ovf       <= nib_a[3] ^ nib_b[3] ^ nib_s[3] ^ nib_c;
`endif
          end else begin
            idx <= idx + IW'(1);
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            busy      <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end else begin
            out_valid <= 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          out_valid <= 1'b0;
          busy      <= 1'b0;
          in_ready  <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_rca_nibble_seq.sv
// Scoreboard bench for rca_nibble_seq at WIDTH=16; checks ovf when RCA_NIBBLE_SEQ_OVF_EN is defined.

module tb_rca_nibble_seq;
  localparam int WIDTH = 16;
  localparam int N     = WIDTH / 4;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              in_valid;
  logic              in_ready;
  logic [WIDTH-1:0]  a;
  logic [WIDTH-1:0]  b;
  logic              cin;
  logic              out_valid;
  logic              out_ready;
  logic [WIDTH-1:0]  s;
  logic              cout;
  logic              busy;
`ifdef RCA_NIBBLE_SEQ_OVF_EN
  logic              ovf;
`endif

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  typedef struct packed {
    logic [WIDTH-1:0] s;
    logic             c;
    logic             v;
  } exp_t;

  exp_t sb[$];

  rca_nibble_seq #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .s         (s),
    .cout      (cout),
    .busy      (busy)
`ifdef RCA_NIBBLE_SEQ_OVF_EN
    , .ovf     (ovf)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic exp_t model(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y, input logic ci);
    logic [WIDTH:0] t;
    exp_t e;
    t   = {1'b0, x} + {1'b0, y} + {{WIDTH{1'b0}}, ci};
    e.s = t[WIDTH-1:0];
    e.c = t[WIDTH];
    e.v = (x[WIDTH-1] == y[WIDTH-1]) && (t[WIDTH-1] != x[WIDTH-1]);
    return e;
  endfunction

  // Waits for in_ready, presents one operand set for the accepting edge and records the expectation.
  task automatic send(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y, input logic ci, output int t_acc);
    int n = 0;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (in_ready !== 1'b1) begin
      bad++;
      $display("FAIL send_ready: in_ready=%b required 1", in_ready);
    end
    a = x; b = y; cin = ci; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    sb.push_back(model(x, y, ci));
    t_acc = cyc;
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    while (!out_valid && lat < 50) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; cin = 1'b0;
    repeat (2) @(negedge clk);
    total += 4;
    if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_out_valid: got %b want 0", out_valid); end
    if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy: got %b want 0", busy); end
    if (s !== 16'h0000) begin bad++; $display("FAIL rst_s: got %h want 0000", s); end
    if (cout !== 1'b0) begin bad++; $display("FAIL rst_cout: got %b want 0", cout); end
`ifdef RCA_NIBBLE_SEQ_OVF_EN
    total++;
    if (ovf !== 1'b0) begin bad++; $display("FAIL rst_ovf: got %b want 0", ovf); end
`endif
    rst_n = 1'b1;
    @(negedge clk);
    total++;
    if (in_ready !== 1'b1) begin bad++; $display("FAIL rst_in_ready: got %b want 1", in_ready); end
  endtask

  task automatic test_basic();
    logic [WIDTH-1:0] va [7];
    logic [WIDTH-1:0] vb [7];
    logic             vc [7];
    int t, lat;
    exp_t e;
    va[0] = 16'h1234; vb[0] = 16'h4321; vc[0] = 1'b0;
    va[1] = 16'hFFFF; vb[1] = 16'h0000; vc[1] = 1'b1;
    va[2] = 16'h7FFF; vb[2] = 16'h0001; vc[2] = 1'b0;
    va[3] = 16'h8000; vb[3] = 16'h8000; vc[3] = 1'b0;
    for (int i = 4; i < 7; i++) begin
      va[i] = 16'($urandom); vb[i] = 16'($urandom); vc[i] = 1'($urandom);
    end
    for (int i = 0; i < 7; i++) begin
      send(va[i], vb[i], vc[i], t);
      wait_valid(lat);
      e = sb.pop_front();
      total += 4;
      if (lat !== N) begin bad++; $display("FAIL basic_latency[%0d]: got %0d want %0d", i, lat, N); end
      if (busy !== 1'b1) begin bad++; $display("FAIL basic_busy[%0d]: got %b want 1", i, busy); end
      if (s !== e.s) begin bad++; $display("FAIL basic_s[%0d]: got %h want %h", i, s, e.s); end
      if (cout !== e.c) begin bad++; $display("FAIL basic_cout[%0d]: got %b want %b", i, cout, e.c); end
`ifdef RCA_NIBBLE_SEQ_OVF_EN
      total++;
      if (ovf !== e.v) begin bad++; $display("FAIL basic_ovf[%0d]: got %b want %b", i, ovf, e.v); end
`endif
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      total++;
      if (out_valid !== 1'b0) begin bad++; $display("FAIL basic_drop[%0d]: got %b want 0", i, out_valid); end
    end
  endtask

  task automatic test_backpressure();
    int t, lat;
    exp_t e;
    send(16'h00F0, 16'h0010, 1'b0, t);
    wait_valid(lat);
    e = sb.pop_front();
    for (int k = 0; k < 5; k++) begin
      total += 4;
      if (out_valid !== 1'b1) begin bad++; $display("FAIL bp_valid[%0d]: got %b want 1", k, out_valid); end
      if (s !== e.s) begin bad++; $display("FAIL bp_s[%0d]: got %h want %h", k, s, e.s); end
      if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_in_ready[%0d]: got %b want 0", k, in_ready); end
      if (busy !== 1'b1) begin bad++; $display("FAIL bp_busy[%0d]: got %b want 1", k, busy); end
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    total += 3;
    if (out_valid !== 1'b0) begin bad++; $display("FAIL bp_drop: got %b want 0", out_valid); end
    if (in_ready !== 1'b1) begin bad++; $display("FAIL bp_in_ready_rise: got %b want 1", in_ready); end
    if (busy !== 1'b0) begin bad++; $display("FAIL bp_busy_clear: got %b want 0", busy); end
  endtask

  task automatic test_operand_change();
    int t, lat;
    exp_t e;
    send(16'hAAAA, 16'h5555, 1'b0, t);
    lat = 0;
    while (!out_valid && lat < 50) begin
      a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom);
      in_valid = 1'($urandom);
      @(negedge clk);
      lat++;
    end
    in_valid = 1'b0;
    e = sb.pop_front();
    total += 3;
    if (out_valid !== 1'b1) begin bad++; $display("FAIL chg_valid: got %b want 1", out_valid); end
    if (s !== e.s) begin bad++; $display("FAIL chg_s: got %h want %h", s, e.s); end
    if (cout !== e.c) begin bad++; $display("FAIL chg_cout: got %b want %b", cout, e.c); end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    int t, lat;
    exp_t e;
    send(16'h1111, 16'h2222, 1'b1, t);
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    void'(sb.pop_back());
    total += 4;
    if (s !== 16'h0000) begin bad++; $display("FAIL mid_s: got %h want 0000", s); end
    if (cout !== 1'b0) begin bad++; $display("FAIL mid_cout: got %b want 0", cout); end
    if (out_valid !== 1'b0) begin bad++; $display("FAIL mid_valid: got %b want 0", out_valid); end
    if (busy !== 1'b0) begin bad++; $display("FAIL mid_busy: got %b want 0", busy); end
    rst_n = 1'b1;
    @(negedge clk);
    total++;
    if (in_ready !== 1'b1) begin bad++; $display("FAIL mid_in_ready: got %b want 1", in_ready); end
    send(16'h0001, 16'h0001, 1'b0, t);
    wait_valid(lat);
    e = sb.pop_front();
    total += 2;
    if (out_valid !== 1'b1) begin bad++; $display("FAIL mid_new_valid: got %b want 1", out_valid); end
    if (s !== e.s) begin bad++; $display("FAIL mid_new_s: got %h want %h", s, e.s); end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    int t, t_prev, lat;
    exp_t e;
    out_ready = 1'b1;
    t_prev = 0;
    for (int i = 0; i < 4; i++) begin
      send(16'($urandom), 16'($urandom), 1'($urandom), t);
      wait_valid(lat);
      e = sb.pop_front();
      total += 3;
      if (out_valid !== 1'b1) begin bad++; $display("FAIL b2b_valid[%0d]: got %b want 1", i, out_valid); end
      if (s !== e.s) begin bad++; $display("FAIL b2b_s[%0d]: got %h want %h", i, s, e.s); end
      if (cout !== e.c) begin bad++; $display("FAIL b2b_cout[%0d]: got %b want %b", i, cout, e.c); end
      if (i > 0) begin
        total++;
        if ((t - t_prev) !== N + 2) begin bad++; $display("FAIL b2b_period[%0d]: got %0d want %0d", i, t - t_prev, N + 2); end
      end
      t_prev = t;
    end
    @(negedge clk);
    out_ready = 1'b0;
    total++;
    if (sb.size() !== 0) begin bad++; $display("FAIL sb_empty: got %0d entries want 0", sb.size()); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_operand_change();
    test_reset_mid();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
